// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and sticky overflow / underflow flags.
//
// Optional build macro: SYNC_FIFO_FWFT_EN
//   undefined : standard read mode. rdata is registered on the accepting
//               edge, and rvalid is a one-cycle pulse aligned with it.
//   defined   : first-word-fall-through mode. rdata shows the head entry
//               whenever the FIFO is not empty, and rvalid = !empty.
//
// Pointers are ADDR_W+1 bits wide. The extra MSB distinguishes full from
// empty when the address bits are equal.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AE_LEVEL);

  // Storage and pointer state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_d;
  logic                  overflow_q;
  logic                  overflow_d;
  logic                  underflow_q;
  logic                  underflow_d;

  // Decoded status, all taken from registered pointers only
  logic [ADDR_W-1:0]     wr_addr_s;
  logic [ADDR_W-1:0]     rd_addr_s;
  logic [PTR_W-1:0]      count_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  assign wr_addr_s = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr_s = rd_ptr_q[ADDR_W-1:0];

  // Status decode from the registered pointers. The count subtraction wraps
  // modulo 2^PTR_W, which gives the occupancy across any number of wraps.
  always_comb begin
    count_s = wr_ptr_q - rd_ptr_q;
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_addr_s == rd_addr_s);
  end

  // Accept decisions use the flags sampled before the edge. On a full FIFO a
  // concurrent read is accepted and the write is dropped. On an empty FIFO
  // the write is accepted and the read is dropped.
  always_comb begin
    wr_acc_s = wr_en && !full_s;
    rd_acc_s = rd_en && !empty_s;
  end

  // Next-state for the pointers and the sticky error flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (wr_en && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (rd_en && empty_s) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Pointer and error-flag registers. Reset takes priority over all requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array. It is not reset; only accepted writes land. The write is
  // gated by rst, so a write presented during reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_q[wr_addr_s] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // First-word-fall-through mode
  logic [DATA_WIDTH-1:0] rdata_s;

  // Present the head entry whenever data is stored, otherwise zero
  always_comb begin
    if (empty_s) begin
      rdata_s = {DATA_WIDTH{1'b0}};
    end else begin
      rdata_s = mem_q[rd_addr_s];
    end
  end

  assign rdata  = rdata_s;
  assign rvalid = !empty_s;
`else
  // Standard read mode: registered read data and a one-cycle valid pulse
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  rvalid_q;
  logic                  rvalid_d;

  // Capture the head entry on an accepted read; otherwise hold the last word
  always_comb begin
    if (rd_acc_s) begin
      rdata_d  = mem_q[rd_addr_s];
      rvalid_d = 1'b1;
    end else begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
    end
  end

  // Read-data and valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= {DATA_WIDTH{1'b0}};
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

  // Output status. All of it is derived from registered state.
  assign count        = count_s;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_s >= AF_THRESH);
  assign almost_empty = (count_s <= AE_THRESH);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Scoreboard bench for sync_fifo_param with default parameters.
// The expected pop data is taken from a queue, and the flags come from the
// model occupancy.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = DEPTH - 2;
  localparam int AE_LVL = 2;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int            tests_run;
  int            tests_failed;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_rdata;
  logic          model_ovf;
  logic          model_udf;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (AF_LVL),
    .AE_LEVEL  (AE_LVL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wdata       (wdata),
    .rd_en       (rd_en),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every status output against the model occupancy
  task automatic check_status();
    int n;
    n = model_q.size();
    check_eq("count", 32'(count), 32'(n));
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("full", 32'(full), 32'(n == DEPTH));
    check_eq("almost_full", 32'(almost_full), 32'(n >= AF_LVL));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE_LVL));
    check_eq("overflow", 32'(overflow), 32'(model_ovf));
    check_eq("underflow", 32'(underflow), 32'(model_udf));
  endtask

  // Hold reset for n cycles, optionally with a write request asserted
  task automatic do_reset(input int n, input logic wr_during);
    rst   = 1'b1;
    wr_en = wr_during;
    wdata = 8'hEE;
    rd_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    model_q.delete();
    model_ovf  = 1'b0;
    model_udf  = 1'b0;
    last_rdata = 8'h00;
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_status();
  endtask

  // Drive one cycle, update the scoreboard and check all outputs after the edge
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd);
    logic          wacc;
    logic          racc;
    logic [DW-1:0] exp_pop;
    wacc = wr && (model_q.size() != DEPTH);
    racc = rd && (model_q.size() != 0);
    if (wr && !wacc) model_ovf = 1'b1;
    if (rd && !racc) model_udf = 1'b1;
    exp_pop = last_rdata;
    if (racc) exp_pop = model_q.pop_front();
    if (wacc) model_q.push_back(wd);
    wr_en = wr;
    wdata = wd;
    rd_en = rd;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    check_eq("rvalid", 32'(rvalid), 32'(model_q.size() != 0));
    check_eq("rdata", 32'(rdata), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
`else
    check_eq("rvalid", 32'(rvalid), 32'(racc));
    check_eq("rdata", 32'(rdata), 32'(exp_pop));
    last_rdata = exp_pop;
`endif
    check_status();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = 8'h00;

    // Reset then idle
    do_reset(2, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Fill with 0x01..0x08, then write while full
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Drain in order, then read while empty
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Simultaneous operations at count 4 across several pointer wraps
    do_reset(1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    step(1'b1, 8'hBC, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous read and write on an empty FIFO: only the write lands
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-stream, with a write asserted during reset
    do_reset(1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    do_reset(1, 1'b1);
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Word written to an empty FIFO and then popped
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic
    do_reset(1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    while (model_q.size() != 0) step(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
